vga_framebuffer: RTL and testbench



---
 rtl/vga_framebuffer.sv | 208 ++++++++++++++++++++
 tb/tb_vga_framebuffer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_framebuffer.sv
// vga_framebuffer: 160x120x3 framebuffer with single-pixel plot writes and
// 640x480@60 VGA scan-out, each stored pixel shown as a 4x4 block.
// Optional power-on clear to BACKGROUND is enabled by defining FB_CLEAR_EN.
module vga_framebuffer #(
  parameter logic [2:0] BACKGROUND = 3'b000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] x,
  input  logic [6:0] y,
  input  logic [2:0] colour,
  input  logic       plot,
  output logic       busy,
  output logic       VGA_CLK,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_BLANK_N,
  output logic       VGA_SYNC_N,
  output logic [7:0] VGA_R,
  output logic [7:0] VGA_G,
  output logic [7:0] VGA_B
);

  localparam int unsigned FB_W         = 160;
  localparam int unsigned FB_H         = 120;
  localparam int unsigned FB_DEPTH     = FB_W * FB_H;
  localparam int unsigned ADDR_W       = 15;
  localparam int unsigned CNT_W        = 10;
  localparam int unsigned H_TOTAL      = 800;
  localparam int unsigned H_VIS        = 640;
  localparam int unsigned H_SYNC_START = 656;
  localparam int unsigned H_SYNC_END   = 751;
  localparam int unsigned V_TOTAL      = 525;
  localparam int unsigned V_VIS        = 480;
  localparam int unsigned V_SYNC_START = 490;
  localparam int unsigned V_SYNC_END   = 491;

  logic [2:0]        mem [FB_DEPTH];

  logic              pe_q;
  logic              pe_tick;
  logic [CNT_W-1:0]  hcount_q, hcount_d;
  logic [CNT_W-1:0]  vcount_q, vcount_d;

  logic              vis_raw, hs_raw, vs_raw;
  logic [ADDR_W-1:0] scan_addr;
  logic [ADDR_W-1:0] rd_addr_q;
  logic              vis1_q, hs1_q, vs1_q;
  logic [2:0]        rdata_q;
  logic              vis2_q, hs2_q, vs2_q;
  logic              hs_out_q, vs_out_q, blank_out_q;
  logic [7:0]        r_q, g_q, b_q;

  logic              plot_ok;
  logic [ADDR_W-1:0] plot_addr;
  logic              clearing;
  logic [ADDR_W-1:0] clear_addr;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [2:0]        wdata;

  // Pixel enable: pe_q rises on every other edge; counters and pipeline move on those edges
  assign pe_tick = ~pe_q;

  // Pixel-enable toggle
  always_ff @(posedge CLOCK_50) begin
    if (reset) pe_q <= 1'b0;
    else       pe_q <= ~pe_q;
  end

  // Next raster position: hcount wraps into vcount, vcount wraps at end of frame
  always_comb begin
    hcount_d = hcount_q;
    vcount_d = vcount_q;
    if (pe_tick) begin
      if (hcount_q == CNT_W'(H_TOTAL - 1)) begin
        hcount_d = '0;
        vcount_d = (vcount_q == CNT_W'(V_TOTAL - 1)) ? '0 : vcount_q + CNT_W'(1);
      end else begin
        hcount_d = hcount_q + CNT_W'(1);
      end
    end
  end

  // Raster counter registers
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      hcount_q <= '0;
      vcount_q <= '0;
    end else begin
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
    end
  end

  // Raw timing flags and block address for the current raster position
  always_comb begin
    vis_raw   = (hcount_q < CNT_W'(H_VIS)) && (vcount_q < CNT_W'(V_VIS));
    hs_raw    = ~((hcount_q >= CNT_W'(H_SYNC_START)) && (hcount_q <= CNT_W'(H_SYNC_END)));
    vs_raw    = ~((vcount_q >= CNT_W'(V_SYNC_START)) && (vcount_q <= CNT_W'(V_SYNC_END)));
    scan_addr = ADDR_W'(vcount_q[CNT_W-1:2]) * ADDR_W'(FB_W) + ADDR_W'(hcount_q[CNT_W-1:2]);
  end

  // Stage 1: latch read address (visible only) and raw flags
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      rd_addr_q <= '0;
      vis1_q    <= 1'b0;
      hs1_q     <= 1'b1;
      vs1_q     <= 1'b1;
    end else if (pe_tick) begin
      if (vis_raw) rd_addr_q <= scan_addr;
      vis1_q <= vis_raw;
      hs1_q  <= hs_raw;
      vs1_q  <= vs_raw;
    end
  end

  // Stage 2 flags travel alongside the RAM read
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      vis2_q <= 1'b0;
      hs2_q  <= 1'b1;
      vs2_q  <= 1'b1;
    end else if (pe_tick) begin
      vis2_q <= vis1_q;
      hs2_q  <= hs1_q;
      vs2_q  <= vs1_q;
    end
  end

  // Output registers: colour expansion, forced black while blanked
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      hs_out_q    <= 1'b1;
      vs_out_q    <= 1'b1;
      blank_out_q <= 1'b0;
      r_q         <= '0;
      g_q         <= '0;
      b_q         <= '0;
    end else if (pe_tick) begin
      hs_out_q    <= hs2_q;
      vs_out_q    <= vs2_q;
      blank_out_q <= vis2_q;
      r_q         <= vis2_q ? {8{rdata_q[2]}} : 8'h00;
      g_q         <= vis2_q ? {8{rdata_q[1]}} : 8'h00;
      b_q         <= vis2_q ? {8{rdata_q[0]}} : 8'h00;
    end
  end

  // Plot acceptance: in-range and not clearing; address never aliases
  assign plot_ok   = plot && (x < 8'(FB_W)) && (y < 7'(FB_H)) && !busy;
  assign plot_addr = ADDR_W'(y) * ADDR_W'(FB_W) + ADDR_W'(x);

`ifdef FB_CLEAR_EN
  logic              busy_q, busy_d;
  logic [ADDR_W-1:0] clear_addr_q, clear_addr_d;

  // Clear sweep: one address per cycle, busy drops after the last one
  always_comb begin
    busy_d       = busy_q;
    clear_addr_d = clear_addr_q;
    if (busy_q) begin
      if (clear_addr_q == ADDR_W'(FB_DEPTH - 1)) busy_d = 1'b0;
      else clear_addr_d = clear_addr_q + ADDR_W'(1);
    end
  end

  // Clear state registers; reset restarts the sweep
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      busy_q       <= 1'b1;
      clear_addr_q <= '0;
    end else begin
      busy_q       <= busy_d;
      clear_addr_q <= clear_addr_d;
    end
  end

  assign busy       = busy_q;
  assign clearing   = busy_q && !reset;
  assign clear_addr = clear_addr_q;
`else
  assign busy       = 1'b0;
  assign clearing   = 1'b0;
  assign clear_addr = '0;
`endif

  assign we    = clearing || plot_ok;
  assign waddr = clearing ? clear_addr : plot_addr;
  assign wdata = clearing ? BACKGROUND : colour;

  // Dual-port RAM: same-address read and write on one edge returns old data
  always_ff @(posedge CLOCK_50) begin
    if (we) mem[waddr] <= wdata;
    if (pe_tick && vis1_q) rdata_q <= mem[rd_addr_q];
  end

  assign VGA_CLK     = pe_q;
  assign VGA_HS      = hs_out_q;
  assign VGA_VS      = vs_out_q;
  assign VGA_BLANK_N = blank_out_q;
  assign VGA_SYNC_N  = 1'b0;
  assign VGA_R       = r_q;
  assign VGA_G       = g_q;
  assign VGA_B       = b_q;

endmodule

// File: tb/tb_vga_framebuffer.sv
// tb_vga_framebuffer: randomized plots against a pixel-index reference model
// of the VGA raster; also measures sync/blank widths directly on the pins.
module tb_vga_framebuffer;

  localparam int unsigned FB_W     = 160;
  localparam int unsigned FB_H     = 120;
  localparam int unsigned FB_DEPTH = FB_W * FB_H;
  localparam logic [2:0]  BG       = 3'b000;
`ifdef FB_CLEAR_EN
  localparam bit CLEAR_EN = 1'b1;
`else
  localparam bit CLEAR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       plot;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       busy, vga_clk, hs, vs, blank_n, sync_n;
  logic [7:0] r, g, b;

  vga_framebuffer #(.BACKGROUND(BG)) dut (
    .CLOCK_50   (clk),
    .reset      (reset),
    .x          (x),
    .y          (y),
    .colour     (colour),
    .plot       (plot),
    .busy       (busy),
    .VGA_CLK    (vga_clk),
    .VGA_HS     (hs),
    .VGA_VS     (vs),
    .VGA_BLANK_N(blank_n),
    .VGA_SYNC_N (sync_n),
    .VGA_R      (r),
    .VGA_G      (g),
    .VGA_B      (b)
  );

  always #10 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at t=%0t", tag, got, exp, $time);
  endtask

  function automatic logic [23:0] dac(input logic [2:0] c);
    return {{8{c[2]}}, {8{c[1]}}, {8{c[0]}}};
  endfunction

  // Reference model: n counts edges since reset released. The pixel clock
  // index p shows on the pins at edge 2p+5 and its RAM read happens at 2p+3.
  int unsigned n = 0;
  bit          live = 1'b0;
  logic [2:0]  fb_m [FB_DEPTH];
  logic [2:0]  rd_col;
  logic        exp_hs, exp_vs, exp_blank, exp_busy;
  logic [23:0] exp_rgb;

  always @(posedge clk) begin
    int unsigned p, h, v;
    live = 1'b1;
    if (reset) begin
      n         = 0;
      exp_hs    = 1'b1;
      exp_vs    = 1'b1;
      exp_blank = 1'b0;
      exp_rgb   = 24'h0;
      exp_busy  = CLEAR_EN;
    end else begin
      n++;
      if (n >= 5 && n % 2 == 1) begin
        p = (n - 5) / 2;
        h = p % 800;
        v = (p / 800) % 525;
        exp_hs    = !(h >= 656 && h <= 751);
        exp_vs    = !(v >= 490 && v <= 491);
        exp_blank = (h < 640) && (v < 480);
        exp_rgb   = exp_blank ? dac(rd_col) : 24'h0;
      end
      if (n >= 3 && n % 2 == 1) begin
        p = (n - 3) / 2;
        h = p % 800;
        v = (p / 800) % 525;
        if (h < 640 && v < 480) rd_col = fb_m[(v / 4) * FB_W + h / 4];
      end
      if (CLEAR_EN && n <= FB_DEPTH) fb_m[n - 1] = BG;
      else if (plot && x < 8'(FB_W) && y < 7'(FB_H)) fb_m[int'(y) * FB_W + int'(x)] = colour;
      exp_busy = CLEAR_EN && (n < FB_DEPTH);
    end
  end

  // Per-cycle pin checks plus direct run-length measurement of HS and BLANK_N
  int unsigned cyc = 0, hs_low = 0, last_fall = 0, blank_run = 0;
  bit          seen_fall = 1'b0;
  logic        hs_prev = 1'b1, blank_prev = 1'b0;

  always @(negedge clk) begin
    if (live) begin
      check_eq("pins", {26'd0, vga_clk, hs, vs, blank_n, sync_n, busy},
               {26'd0, 1'(n % 2), exp_hs, exp_vs, exp_blank, 1'b0, exp_busy});
      if (!$isunknown(exp_rgb)) check_eq("rgb", {8'd0, r, g, b}, {8'd0, exp_rgb});
      if (n == 0) begin
        hs_low     = 0;
        blank_run  = 0;
        seen_fall  = 1'b0;
        hs_prev    = 1'b1;
        blank_prev = 1'b0;
      end else begin
        cyc++;
        if (!hs) hs_low++;
        if (hs_prev && !hs) begin
          if (seen_fall) check_eq("hs_period", cyc - last_fall, 1600);
          seen_fall = 1'b1;
          last_fall = cyc;
        end
        if (!hs_prev && hs) begin
          check_eq("hs_low_cycles", hs_low, 192);
          hs_low = 0;
        end
        if (blank_n) blank_run++;
        if (blank_prev && !blank_n) begin
          check_eq("blank_cycles", blank_run, 1280);
          blank_run = 0;
        end
        hs_prev    = hs;
        blank_prev = blank_n;
      end
    end
  end

  task automatic plot_px(input logic [7:0] px, input logic [6:0] py, input logic [2:0] c);
    plot = 1'b1; x = px; y = py; colour = c;
    @(negedge clk);
  endtask

  // Plot so the write lands on the same edge the read of that address issues
  task automatic collide();
    int unsigned nt, p, h, v, a;
    nt = n + 41;
    if (nt % 2 == 0) nt++;
    p = (nt - 3) / 2; h = p % 800; v = (p / 800) % 525;
    if (h >= 640) begin
      nt += 2 * (800 - h);
      p = (nt - 3) / 2; h = p % 800; v = (p / 800) % 525;
    end
    plot = 1'b0;
    while (n + 1 < nt) @(negedge clk);
    a = (v / 4) * FB_W + h / 4;
    colour = $isunknown(fb_m[a]) ? 3'b101 : ~fb_m[a];
    x = 8'(h / 4); y = 7'(v / 4); plot = 1'b1;
    @(negedge clk);
    plot = 1'b0;
  endtask

  initial begin
    int unsigned cnt;
    reset = 1'b1; plot = 1'b0; x = '0; y = '0; colour = '0;
    repeat (4) @(negedge clk);
    check_eq("reset_pins", {3'd0, vga_clk, hs, vs, blank_n, sync_n, r, g, b},
             {3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 24'h0});
    check_eq("reset_busy", 32'(busy), 32'(CLEAR_EN));
    reset = 1'b0;

`ifdef FB_CLEAR_EN
    repeat (5000) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    cnt = 0;
    while (busy === 1'b1 && cnt < 25000) begin
      plot = (cnt == 100); x = 8'd7; y = 7'd9; colour = 3'b111;
      @(negedge clk);
      cnt++;
    end
    plot = 1'b0;
    check_eq("busy_cycles", cnt, 19200);
`endif

    for (int i = 0; i < 9 * int'(FB_W); i++)
      plot_px(8'(i % FB_W), 7'(i / FB_W), 3'($urandom_range(0, 7)));
    plot_px(8'd0,   7'd0,   3'b100);
    plot_px(8'd159, 7'd119, 3'b011);
    plot_px(8'd160, 7'd0,   3'b111);
    plot_px(8'd0,   7'd120, 3'b111);
    plot_px(8'd255, 7'd127, 3'b111);
    plot = 1'b0;

`ifndef FB_CLEAR_EN
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
`endif

    while (n < 59000) begin
      if (n % 5000 == 0) begin
        collide();
      end else begin
        plot = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 7) == 0) begin
          x = 8'($urandom_range(0, 255));
          y = 7'($urandom_range(0, 127));
        end else begin
          x = 8'($urandom_range(0, 159));
          y = 7'($urandom_range(0, 9));
        end
        colour = 3'($urandom_range(0, 7));
        @(negedge clk);
      end
    end
    plot = 1'b0;
    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
